multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit. Replaces the single-cycle combinational decoder with an opcode-driven state machine that sequences fetch, decode, execute, memory and write-back over several cycles on a shared datapath and single memory port. It adds a variable-latency memory handshake with timeout, illegal-opcode detection and a one-cycle trap sequence. It sits between the instruction register opcode field and the multi-cycle datapath muxes/enables.

## Interface
- MEM_TIMEOUT, 16: max wait cycles with mem_ready low before a bus-error trap; 0 disables the timeout; legal range 0..255.
- IMM_ALU_EN, 1: 1 = addi/andi decoded; 0 = those opcodes are illegal.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  instruction opcode (IR[31:26]), sampled in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pcWr, pcWrCondEq, pcWrCondNe  out  1  unconditional / beq / bne PC write enables.
- iOrD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRd, memWr  out  1  memory strobes, held until mem_ready.
- irWr  out  1  instruction register load.
- mem2Reg, regDst, regWr  out  1  write-back select, rd/rt select, register write.
- ALUSrcA  out  1  0 = PC, 1 = reg A.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 and.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector.
- trap  out  1  high for the single TRAP-state cycle.
- cause  out  2  sticky: 00 none, 01 illegal opcode, 10 bus timeout.
- state  out  4  current state encoding, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12. Codes 13-15 go to TRAP with cause 01.
- FETCH: memRd=1, iOrD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. irWr=pcWr=mem_ready. Leaves to DECODE only when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next: 000000→R_EXEC; 100011/101011→MEM_ADDR; 000100/000101→BRANCH; 000010→JUMP; 001000/001100→I_EXEC if IMM_ALU_EN, else TRAP; any other→TRAP, cause 01.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: memRd=1, iOrD=1; to MEM_WB on mem_ready. MEM_WB: regWr=1, mem2Reg=1, regDst=0; then FETCH.
- MEM_WRITE: memWr=1, iOrD=1; to FETCH on mem_ready.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. R_WB: regWr=1, regDst=1, mem2Reg=0; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; pcWrCondEq=1 for beq, pcWrCondNe=1 for bne; then FETCH.
- JUMP: pcWr=1, PCSource=10; then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 (addi) or 11 (andi). I_WB: regWr=1, regDst=0; then FETCH.
- Opcode is latched in DECODE; later states use the latched copy, not the live input.
- Wait counter: 8-bit. Cleared on entry to FETCH/MEM_READ/MEM_WRITE and whenever mem_ready=1. Increments each wait cycle with mem_ready low. Reaching MEM_TIMEOUT (when nonzero) forces TRAP with cause 10. No strobe or write enable fires on that cycle.
- TRAP: trap=1, pcWr=1, PCSource=11, all other enables 0; then FETCH.
- cause updates only on trap entry and clears only on reset. An illegal opcode has priority, since it cannot coincide with a wait.
- Any output not listed for a state is 0.

## Timing
- Reset: state=FETCH, counter=0, cause=00, latched opcode=0. While rst_n is low, all outputs are forced to 0 asynchronously. The first FETCH strobe appears in the cycle after rst_n rises.
- Reset mid-instruction aborts immediately. No write enable is asserted after rst_n falls.
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3, illegal 3 (FETCH, DECODE, TRAP).
- Each cycle with mem_ready low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Timeout: with mem_ready held low, TRAP is entered MEM_TIMEOUT cycles after entering the wait state.
- mem_ready high in any non-wait state is ignored.

## Test plan
- Zero-wait R-type (opcode 000000, mem_ready=1) → states 0,1,6,7,0; regWr=1 and regDst=1 only in cycle 4.
- lw with 2 wait cycles in MEM_READ → 7 cycles total; memRd held for 3 cycles in MEM_READ; regWr=1 with mem2Reg=1 once, in MEM_WB.
- bne (000101) → pcWrCondNe=1 with ALUOp=01 and PCSource=01 in cycle 3; pcWrCondEq stays 0; back to FETCH.
- Illegal opcode 111111 → TRAP in cycle 3 with trap=1, PCSource=11, cause=01; and 001000 with IMM_ALU_EN=0 → same response.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH → TRAP 4 cycles after FETCH entry; irWr never asserted; cause=10.
- rst_n dropped while in MEM_WRITE → memWr=0 immediately; after release: state=0, cause=00, first fetch completes normally.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit.
// Sequences fetch/decode/execute/memory/write-back on a shared datapath,
// waits on a variable-latency memory port with an optional timeout, and
// traps on illegal opcodes or bus timeouts with a sticky cause code.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          IMM_ALU_EN  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcWr,
   output logic       pcWrCondEq,
   output logic       pcWrCondNe,
   output logic       iOrD,
   output logic       memRd,
   output logic       memWr,
   output logic       irWr,
   output logic       mem2Reg,
   output logic       regDst,
   output logic       regWr,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       trap,
   output logic [1:0] cause,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_I_EXEC    = 4'd10;
   localparam logic [3:0] S_I_WB      = 4'd11;
   localparam logic [3:0] S_TRAP      = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // Timeout fires when the count would reach MEM_TIMEOUT on this wait cycle,
   // so TRAP is entered exactly MEM_TIMEOUT cycles after the wait state began.
   localparam bit         TMO_EN  = (MEM_TIMEOUT != 0);
   localparam logic [8:0] TMO_CNT = 9'(MEM_TIMEOUT);

   logic [3:0] state_r;
   logic [3:0] next_s;
   logic [5:0] op_r;
   logic [7:0] wait_cnt_r;
   logic [1:0] cause_r;
   logic       is_wait_s;
   logic       timeout_s;
   logic       illegal_s;

   logic       pc_wr_s, cond_eq_s, cond_ne_s, i_or_d_s, mem_rd_s, mem_wr_s;
   logic       ir_wr_s, mem2reg_s, reg_dst_s, reg_wr_s, alu_src_a_s, trap_s;
   logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

   assign is_wait_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                      (state_r == S_MEM_WRITE);
   assign timeout_s = TMO_EN && is_wait_s && !mem_ready &&
                      (({1'b0, wait_cnt_r} + 9'd1) == TMO_CNT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode; flags illegal-opcode trap entries for the cause logic.
   always_comb begin
      next_s    = state_r;
      illegal_s = 1'b0;
      case (state_r)
         S_FETCH: begin
            if (timeout_s)      next_s = S_TRAP;
            else if (mem_ready) next_s = S_DECODE;
            else                next_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      next_s = S_R_EXEC;
               OP_LW, OP_SW:  next_s = S_MEM_ADDR;
               OP_BEQ, OP_BNE: next_s = S_BRANCH;
               OP_J:          next_s = S_JUMP;
               OP_ADDI, OP_ANDI: begin
                  if (IMM_ALU_EN) begin
                     next_s = S_I_EXEC;
                  end else begin
                     next_s    = S_TRAP;
                     illegal_s = 1'b1;
                  end
               end
               default: begin
                  next_s    = S_TRAP;
                  illegal_s = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (op_r == OP_SW) next_s = S_MEM_WRITE;
            else               next_s = S_MEM_READ;
         end
         S_MEM_READ: begin
            if (timeout_s)      next_s = S_TRAP;
            else if (mem_ready) next_s = S_MEM_WB;
            else                next_s = S_MEM_READ;
         end
         S_MEM_WB:    next_s = S_FETCH;
         S_MEM_WRITE: begin
            if (timeout_s)      next_s = S_TRAP;
            else if (mem_ready) next_s = S_FETCH;
            else                next_s = S_MEM_WRITE;
         end
         S_R_EXEC: next_s = S_R_WB;
         S_R_WB:   next_s = S_FETCH;
         S_BRANCH: next_s = S_FETCH;
         S_JUMP:   next_s = S_FETCH;
         S_I_EXEC: next_s = S_I_WB;
         S_I_WB:   next_s = S_FETCH;
         S_TRAP:   next_s = S_FETCH;
         default: begin
            next_s    = S_TRAP;
            illegal_s = 1'b1;
         end
      endcase
   end

   // Opcode latch: later states must not depend on the live IR field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r <= 6'd0;
      end else if (state_r == S_DECODE) begin
         op_r <= opcode;
      end else begin
         op_r <= op_r;
      end
   end

   // Memory wait counter: cleared on wait-state entry or completion, saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= 8'd0;
      end else if ((next_s != state_r) &&
                   ((next_s == S_FETCH) || (next_s == S_MEM_READ) ||
                    (next_s == S_MEM_WRITE))) begin
         wait_cnt_r <= 8'd0;
      end else if (mem_ready) begin
         wait_cnt_r <= 8'd0;
      end else if (is_wait_s && (wait_cnt_r != 8'hFF)) begin
         wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Sticky trap cause, written only when TRAP is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_r <= 2'b00;
      end else if ((next_s == S_TRAP) && (state_r != S_TRAP)) begin
         if (illegal_s)      cause_r <= CAUSE_ILLEGAL;
         else if (timeout_s) cause_r <= CAUSE_TIMEOUT;
         else                cause_r <= cause_r;
      end else begin
         cause_r <= cause_r;
      end
   end

   // Per-state datapath controls; the timeout cycle drops the memory strobes.
   always_comb begin
      pc_wr_s     = 1'b0;
      cond_eq_s   = 1'b0;
      cond_ne_s   = 1'b0;
      i_or_d_s    = 1'b0;
      mem_rd_s    = 1'b0;
      mem_wr_s    = 1'b0;
      ir_wr_s     = 1'b0;
      mem2reg_s   = 1'b0;
      reg_dst_s   = 1'b0;
      reg_wr_s    = 1'b0;
      alu_src_a_s = 1'b0;
      alu_src_b_s = 2'b00;
      alu_op_s    = 2'b00;
      pc_source_s = 2'b00;
      trap_s      = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_rd_s    = !timeout_s;
            alu_src_b_s = 2'b01;
            ir_wr_s     = mem_ready;
            pc_wr_s     = mem_ready;
         end
         S_DECODE: begin
            alu_src_b_s = 2'b11;
         end
         S_MEM_ADDR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
         end
         S_MEM_READ: begin
            mem_rd_s = !timeout_s;
            i_or_d_s = 1'b1;
         end
         S_MEM_WB: begin
            reg_wr_s  = 1'b1;
            mem2reg_s = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_wr_s = !timeout_s;
            i_or_d_s = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a_s = 1'b1;
            alu_op_s    = 2'b10;
         end
         S_R_WB: begin
            reg_wr_s  = 1'b1;
            reg_dst_s = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_s = 1'b1;
            alu_op_s    = 2'b01;
            pc_source_s = 2'b01;
            cond_eq_s   = (op_r == OP_BEQ);
            cond_ne_s   = (op_r == OP_BNE);
         end
         S_JUMP: begin
            pc_wr_s     = 1'b1;
            pc_source_s = 2'b10;
         end
         S_I_EXEC: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            if (op_r == OP_ANDI) alu_op_s = 2'b11;
            else                 alu_op_s = 2'b00;
         end
         S_I_WB: begin
            reg_wr_s = 1'b1;
         end
         S_TRAP: begin
            trap_s      = 1'b1;
            pc_wr_s     = 1'b1;
            pc_source_s = 2'b11;
         end
         default: begin
            pc_wr_s = 1'b0;
         end
      endcase
   end

   // All outputs collapse to zero while reset is asserted, without waiting for a clock.
   assign pcWr       = rst_n & pc_wr_s;
   assign pcWrCondEq = rst_n & cond_eq_s;
   assign pcWrCondNe = rst_n & cond_ne_s;
   assign iOrD       = rst_n & i_or_d_s;
   assign memRd      = rst_n & mem_rd_s;
   assign memWr      = rst_n & mem_wr_s;
   assign irWr       = rst_n & ir_wr_s;
   assign mem2Reg    = rst_n & mem2reg_s;
   assign regDst     = rst_n & reg_dst_s;
   assign regWr      = rst_n & reg_wr_s;
   assign ALUSrcA    = rst_n & alu_src_a_s;
   assign ALUSrcB    = {2{rst_n}} & alu_src_b_s;
   assign ALUOp      = {2{rst_n}} & alu_op_s;
   assign PCSource   = {2{rst_n}} & pc_source_s;
   assign trap       = rst_n & trap_s;
   assign cause      = {2{rst_n}} & cause_r;
   assign state      = {4{rst_n}} & state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: instance A uses the default
// parameters, instance B uses MEM_TIMEOUT=4 and IMM_ALU_EN=0.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // Control vector order: pcWr condEq condNe iOrD | memRd memWr irWr mem2Reg |
   // regDst regWr ALUSrcA | ALUSrcB | ALUOp | PCSource | trap
   localparam logic [17:0] V_ZERO   = 18'b0000_0000_000_00_00_00_0;
   localparam logic [17:0] V_FRDY   = 18'b1000_1010_000_01_00_00_0;
   localparam logic [17:0] V_FWAIT  = 18'b0000_1000_000_01_00_00_0;
   localparam logic [17:0] V_DEC    = 18'b0000_0000_000_11_00_00_0;
   localparam logic [17:0] V_REXEC  = 18'b0000_0000_001_00_10_00_0;
   localparam logic [17:0] V_RWB    = 18'b0000_0000_110_00_00_00_0;
   localparam logic [17:0] V_MADDR  = 18'b0000_0000_001_10_00_00_0;
   localparam logic [17:0] V_MREAD  = 18'b0001_1000_000_00_00_00_0;
   localparam logic [17:0] V_MWB    = 18'b0000_0001_010_00_00_00_0;
   localparam logic [17:0] V_MWRITE = 18'b0001_0100_000_00_00_00_0;
   localparam logic [17:0] V_BNE    = 18'b0010_0000_001_00_01_01_0;
   localparam logic [17:0] V_BEQ    = 18'b0100_0000_001_00_01_01_0;
   localparam logic [17:0] V_JUMP   = 18'b1000_0000_000_00_00_10_0;
   localparam logic [17:0] V_ADDI   = 18'b0000_0000_001_10_00_00_0;
   localparam logic [17:0] V_ANDI   = 18'b0000_0000_001_10_11_00_0;
   localparam logic [17:0] V_IWB    = 18'b0000_0000_010_00_00_00_0;
   localparam logic [17:0] V_TRAP   = 18'b1000_0000_000_00_00_11_1;

   logic clk;
   logic rst_n_a, rst_n_b;
   logic [5:0] opcode_a, opcode_b;
   logic mem_ready_a, mem_ready_b;

   logic pcWr_a, pcWrCondEq_a, pcWrCondNe_a, iOrD_a, memRd_a, memWr_a, irWr_a;
   logic mem2Reg_a, regDst_a, regWr_a, ALUSrcA_a, trap_a;
   logic [1:0] ALUSrcB_a, ALUOp_a, PCSource_a, cause_a;
   logic [3:0] state_a;

   logic pcWr_b, pcWrCondEq_b, pcWrCondNe_b, iOrD_b, memRd_b, memWr_b, irWr_b;
   logic mem2Reg_b, regDst_b, regWr_b, ALUSrcA_b, trap_b;
   logic [1:0] ALUSrcB_b, ALUOp_b, PCSource_b, cause_b;
   logic [3:0] state_b;

   logic [17:0] ctl_a, ctl_b;
   int n_tests = 0;
   int n_fail  = 0;

   assign ctl_a = {pcWr_a, pcWrCondEq_a, pcWrCondNe_a, iOrD_a, memRd_a, memWr_a,
                   irWr_a, mem2Reg_a, regDst_a, regWr_a, ALUSrcA_a, ALUSrcB_a,
                   ALUOp_a, PCSource_a, trap_a};
   assign ctl_b = {pcWr_b, pcWrCondEq_b, pcWrCondNe_b, iOrD_b, memRd_b, memWr_b,
                   irWr_b, mem2Reg_b, regDst_b, regWr_b, ALUSrcA_b, ALUSrcB_b,
                   ALUOp_b, PCSource_b, trap_b};

   multicycle_control dut_a (
      .clk(clk), .rst_n(rst_n_a), .opcode(opcode_a), .mem_ready(mem_ready_a),
      .pcWr(pcWr_a), .pcWrCondEq(pcWrCondEq_a), .pcWrCondNe(pcWrCondNe_a),
      .iOrD(iOrD_a), .memRd(memRd_a), .memWr(memWr_a), .irWr(irWr_a),
      .mem2Reg(mem2Reg_a), .regDst(regDst_a), .regWr(regWr_a),
      .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .ALUOp(ALUOp_a),
      .PCSource(PCSource_a), .trap(trap_a), .cause(cause_a), .state(state_a)
   );

   multicycle_control #(.MEM_TIMEOUT(4), .IMM_ALU_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .opcode(opcode_b), .mem_ready(mem_ready_b),
      .pcWr(pcWr_b), .pcWrCondEq(pcWrCondEq_b), .pcWrCondNe(pcWrCondNe_b),
      .iOrD(iOrD_b), .memRd(memRd_b), .memWr(memWr_b), .irWr(irWr_b),
      .mem2Reg(mem2Reg_b), .regDst(regDst_b), .regWr(regWr_b),
      .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b),
      .PCSource(PCSource_b), .trap(trap_b), .cause(cause_b), .state(state_b)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on A, check state/controls/cause, then advance.
   task automatic tc_a(input string tag, input logic rdy, input logic [5:0] op,
                       input logic [3:0] es, input logic [17:0] ec, input logic [1:0] ecause);
      mem_ready_a = rdy;
      opcode_a    = op;
      #1;
      check_eq({tag, "_state"}, {28'd0, state_a}, {28'd0, es});
      check_eq({tag, "_ctl"},   {14'd0, ctl_a},   {14'd0, ec});
      check_eq({tag, "_cause"}, {30'd0, cause_a}, {30'd0, ecause});
      next_cycle();
   endtask

   // Same as tc_a for instance B.
   task automatic tc_b(input string tag, input logic rdy, input logic [5:0] op,
                       input logic [3:0] es, input logic [17:0] ec, input logic [1:0] ecause);
      mem_ready_b = rdy;
      opcode_b    = op;
      #1;
      check_eq({tag, "_state"}, {28'd0, state_b}, {28'd0, es});
      check_eq({tag, "_ctl"},   {14'd0, ctl_b},   {14'd0, ec});
      check_eq({tag, "_cause"}, {30'd0, cause_b}, {30'd0, ecause});
      next_cycle();
   endtask

   initial begin
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      mem_ready_a = 1'b1; opcode_a = OP_R;
      mem_ready_b = 1'b0; opcode_b = OP_R;
      #2;
      check_eq("rst_ctl",   {14'd0, ctl_a},   {14'd0, V_ZERO});
      check_eq("rst_state", {28'd0, state_a}, 32'd0);
      check_eq("rst_cause", {30'd0, cause_a}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n_a = 1'b1;

      // Zero-wait R-type: 0,1,6,7 then back to 0.
      tc_a("r_f",  1'b1, OP_R, 4'd0, V_FRDY,  2'b00);
      tc_a("r_d",  1'b1, OP_R, 4'd1, V_DEC,   2'b00);
      tc_a("r_x",  1'b1, OP_R, 4'd6, V_REXEC, 2'b00);
      tc_a("r_wb", 1'b1, OP_R, 4'd7, V_RWB,   2'b00);

      // lw with two wait cycles; live opcode changed after DECODE.
      tc_a("lw_f",  1'b1, OP_LW, 4'd0, V_FRDY,  2'b00);
      tc_a("lw_d",  1'b1, OP_LW, 4'd1, V_DEC,   2'b00);
      tc_a("lw_a",  1'b1, OP_SW, 4'd2, V_MADDR, 2'b00);
      tc_a("lw_r0", 1'b0, OP_SW, 4'd3, V_MREAD, 2'b00);
      tc_a("lw_r1", 1'b0, OP_SW, 4'd3, V_MREAD, 2'b00);
      tc_a("lw_r2", 1'b1, OP_SW, 4'd3, V_MREAD, 2'b00);
      tc_a("lw_wb", 1'b1, OP_SW, 4'd4, V_MWB,   2'b00);

      // Zero-wait sw.
      tc_a("sw_f", 1'b1, OP_SW, 4'd0, V_FRDY,   2'b00);
      tc_a("sw_d", 1'b1, OP_SW, 4'd1, V_DEC,    2'b00);
      tc_a("sw_a", 1'b1, OP_LW, 4'd2, V_MADDR,  2'b00);
      tc_a("sw_w", 1'b1, OP_LW, 4'd5, V_MWRITE, 2'b00);

      // bne and beq; branch state must use the latched opcode.
      tc_a("bne_f", 1'b1, OP_BNE, 4'd0, V_FRDY, 2'b00);
      tc_a("bne_d", 1'b1, OP_BNE, 4'd1, V_DEC,  2'b00);
      tc_a("bne_x", 1'b1, OP_BEQ, 4'd8, V_BNE,  2'b00);
      tc_a("beq_f", 1'b1, OP_BEQ, 4'd0, V_FRDY, 2'b00);
      tc_a("beq_d", 1'b1, OP_BEQ, 4'd1, V_DEC,  2'b00);
      tc_a("beq_x", 1'b1, OP_BNE, 4'd8, V_BEQ,  2'b00);

      // Jump, andi and addi (fetch of addi takes one wait cycle).
      tc_a("j_f",    1'b1, OP_J,    4'd0,  V_FRDY,  2'b00);
      tc_a("j_d",    1'b1, OP_J,    4'd1,  V_DEC,   2'b00);
      tc_a("j_x",    1'b1, OP_J,    4'd9,  V_JUMP,  2'b00);
      tc_a("andi_f", 1'b1, OP_ANDI, 4'd0,  V_FRDY,  2'b00);
      tc_a("andi_d", 1'b1, OP_ANDI, 4'd1,  V_DEC,   2'b00);
      tc_a("andi_x", 1'b1, OP_ADDI, 4'd10, V_ANDI,  2'b00);
      tc_a("andi_w", 1'b1, OP_ADDI, 4'd11, V_IWB,   2'b00);
      tc_a("addi_w0",1'b0, OP_ADDI, 4'd0,  V_FWAIT, 2'b00);
      tc_a("addi_f", 1'b1, OP_ADDI, 4'd0,  V_FRDY,  2'b00);
      tc_a("addi_d", 1'b1, OP_ADDI, 4'd1,  V_DEC,   2'b00);
      tc_a("addi_x", 1'b1, OP_ANDI, 4'd10, V_ADDI,  2'b00);
      tc_a("addi_w", 1'b1, OP_ANDI, 4'd11, V_IWB,   2'b00);

      // Illegal opcode traps in cycle 3; cause stays set afterwards.
      tc_a("ill_f",  1'b1, OP_R,   4'd0,  V_FRDY,   2'b00);
      tc_a("ill_d",  1'b1, OP_BAD, 4'd1,  V_DEC,    2'b00);
      tc_a("ill_t",  1'b1, OP_R,   4'd12, V_TRAP,   2'b01);
      tc_a("ill_f2", 1'b1, OP_R,   4'd0,  V_FRDY,   2'b01);
      tc_a("ill_d2", 1'b1, OP_SW,  4'd1,  V_DEC,    2'b01);
      tc_a("ill_a2", 1'b1, OP_SW,  4'd2,  V_MADDR,  2'b01);
      tc_a("mw_w0",  1'b0, OP_SW,  4'd5,  V_MWRITE, 2'b01);

      // Reset asserted mid MEM_WRITE: everything drops at once.
      rst_n_a = 1'b0;
      #1;
      check_eq("mrst_ctl",   {14'd0, ctl_a},   {14'd0, V_ZERO});
      check_eq("mrst_state", {28'd0, state_a}, 32'd0);
      check_eq("mrst_cause", {30'd0, cause_a}, 32'd0);
      next_cycle();
      rst_n_a = 1'b1;
      tc_a("rr_f", 1'b1, OP_R, 4'd0, V_FRDY, 2'b00);
      tc_a("rr_d", 1'b1, OP_R, 4'd1, V_DEC,  2'b00);
      tc_a("rr_x", 1'b1, OP_R, 4'd6, V_REXEC,2'b00);

      // Instance B: addi is illegal when immediate ALU ops are disabled.
      rst_n_b = 1'b1;
      tc_b("b_f", 1'b1, OP_ADDI, 4'd0,  V_FRDY, 2'b00);
      tc_b("b_d", 1'b1, OP_ADDI, 4'd1,  V_DEC,  2'b00);
      tc_b("b_t", 1'b0, OP_R,    4'd12, V_TRAP, 2'b01);

      // mem_ready stuck low in FETCH: TRAP four cycles after FETCH entry.
      tc_b("b_w0", 1'b0, OP_R, 4'd0, V_FWAIT, 2'b01);
      tc_b("b_w1", 1'b0, OP_R, 4'd0, V_FWAIT, 2'b01);
      tc_b("b_w2", 1'b0, OP_R, 4'd0, V_FWAIT, 2'b01);
      mem_ready_b = 1'b0;
      #1;
      check_eq("b_w3_state", {28'd0, state_b}, 32'd0);
      check_eq("b_w3_irwr",  {31'd0, irWr_b},  32'd0);
      next_cycle();
      tc_b("b_to",   1'b0, OP_R, 4'd12, V_TRAP,  2'b10);
      tc_b("b_back", 1'b0, OP_R, 4'd0,  V_FWAIT, 2'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
